// File: rtl/unsigned_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Results, done pulse and div_by_zero are registered; start is ignored while busy.
module unsigned_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] res_rem_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH:0]   trial_d;
  logic             ge_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] shift_d;

  // The partial remainder is always below the divisor, so it fits WIDTH bits;
  // only the trial value needs the extra bit.
  always_comb begin
    trial_d = {rem_q, a_q[WIDTH-1]};
    ge_d    = trial_d >= {1'b0, b_q};
    rem_d   = ge_d ? (trial_d[WIDTH-1:0] - b_q) : trial_d[WIDTH-1:0];
    shift_d = {a_q[WIDTH-2:0], ge_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quo_q     <= '0;
      res_rem_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= dividend;
            b_q     <= divisor;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= shift_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            quo_q     <= shift_d;
            res_rem_q <= rem_d;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            dbz_q     <= (b_q == '0);
            state_q   <= IDLE;
          end
        end
      endcase
    end
  end

  assign quotient    = quo_q;
  assign remainder   = res_rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_unsigned_divider.sv
// Directed and random checks of the 8-bit sequential divider.
module tb_unsigned_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  unsigned_divider #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until done is seen (bounded); counts edges and busy-high cycles.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cycles++;
      tick();
      edges++;
    end
  endtask

  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic ez, input string tag);
    int edges, bc;
    start = 1'b1;
    dividend = a;
    divisor = b;
    tick();
    start = 1'b0;
    chk({tag, " busy_after_start"}, busy, 1);
    wait_done(edges, bc);
    chk({tag, " done"}, done, 1);
    chk({tag, " busy_cycles"}, bc, 8);
    chk({tag, " busy_at_done"}, busy, 0);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_by_zero"}, div_by_zero, ez);
    tick();
    chk({tag, " done_single"}, done, 0);
    chk({tag, " quotient_hold"}, quotient, eq);
  endtask

  initial begin
    int edges, bc, ndone;
    logic [7:0] ra, rb, eq, er;

    rst = 1'b1;
    start = 1'b1;
    dividend = 8'd33;
    divisor = 8'd4;
    tick();
    tick();
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset dbz", div_by_zero, 0);
    rst = 1'b0;
    start = 1'b0;

    run_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, "200/7");
    run_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, "255/1");
    run_div(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, "5/9");
    run_div(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, "255/255");
    run_div(8'd0, 8'd3, 8'd0, 8'd0, 1'b0, "0/3");
    run_div(8'd100, 8'd0, 8'd255, 8'd100, 1'b1, "100/0");
    run_div(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, "9/3");

    // A start pulse mid-operation must be ignored.
    start = 1'b1;
    dividend = 8'd200;
    divisor = 8'd7;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    dividend = 8'd50;
    divisor = 8'd5;
    tick();
    start = 1'b0;
    ndone = 0;
    eq = 8'd0;
    er = 8'd0;
    for (int i = 0; i < 15; i++) begin
      if (done) begin
        ndone++;
        eq = quotient;
        er = remainder;
      end
      tick();
    end
    chk("busy_start done_count", ndone, 1);
    chk("busy_start quotient", eq, 28);
    chk("busy_start remainder", er, 4);

    // Back-to-back with start held high; second operands appear on the done cycle.
    start = 1'b1;
    dividend = 8'd81;
    divisor = 8'd9;
    tick();
    wait_done(edges, bc);
    chk("b2b first done", done, 1);
    chk("b2b first busy_cycles", bc, 8);
    chk("b2b first quotient", quotient, 9);
    chk("b2b first remainder", remainder, 0);
    dividend = 8'd17;
    divisor = 8'd4;
    tick();
    start = 1'b0;
    chk("b2b second accepted", busy, 1);
    wait_done(edges, bc);
    chk("b2b second done", done, 1);
    chk("b2b second quotient", quotient, 4);
    chk("b2b second remainder", remainder, 1);
    tick();

    // Reset during RUN aborts without a done pulse.
    start = 1'b1;
    dividend = 8'd200;
    divisor = 8'd7;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    chk("abort dbz", div_by_zero, 0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("abort no_done", ndone, 0);
    run_div(8'd12, 8'd5, 8'd2, 8'd2, 1'b0, "12/5");

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i % 50 == 0) rb = 8'd0;
      eq = (rb == 8'd0) ? 8'hFF : ra / rb;
      er = (rb == 8'd0) ? ra : ra % rb;
      run_div(ra, rb, eq, er, rb == 8'd0, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
